// File: rtl/note_link_pkg.sv
// rtl/note_link_pkg.sv - shared types and default constants for the serial note link
package note_link_pkg;

  // Receiver frame FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } note_state_e;

  // Link defaults, also used by the transmitter side
  localparam int NOTE_COUNT        = 48;
  localparam int NOTE_BIT_PERIOD   = 8192;
  localparam int NOTE_SAMPLE_POINT = 64;

endpackage

// File: rtl/note_bit_timer.sv
// rtl/note_bit_timer.sv - sync edge detect, bit phase counter and sample strobe
module note_bit_timer
  import note_link_pkg::*;
#(
  parameter int BIT_PERIOD   = NOTE_BIT_PERIOD,
  parameter int SAMPLE_POINT = NOTE_SAMPLE_POINT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic sample_tick_o
);

  localparam int PH_W = $clog2(BIT_PERIOD + 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_PERIOD);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_POINT);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            sync_prev_q;
  logic            sync_rise;

  assign sync_rise     = sync_i & ~sync_prev_q;
  assign sample_tick_o = (phase_q == PH_SAMPLE);

  // Phase runs 1..BIT_PERIOD; a sync rising edge realigns it to the start of bit 0
  always_comb begin
    phase_d = phase_q + PH_ONE;
    if (sync_rise) begin
      phase_d = PH_ONE;
    end else if (phase_q == PH_LAST) begin
      phase_d = PH_ONE;
    end
  end

  // Phase and previous-sync registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= PH_ONE;
      sync_prev_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sync_prev_q <= sync_i;
    end
  end

endmodule

// File: rtl/note_frame_receiver.sv
// rtl/note_frame_receiver.sv - serial note frame receiver with link supervision; NOTE_FRAME_PARITY_EN adds an even-parity bit
module note_frame_receiver
  import note_link_pkg::*;
#(
  parameter int NUM_NOTES    = NOTE_COUNT,
  parameter int BIT_PERIOD   = NOTE_BIT_PERIOD,
  parameter int SAMPLE_POINT = NOTE_SAMPLE_POINT,
  parameter int TIMEOUT_BITS = 96
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 note_serial_sync,
  input  logic                 note_serial_data,
  output logic [NUM_NOTES-1:0] active,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic                 link_up
);

`ifdef NOTE_FRAME_PARITY_EN
  localparam int FRAME_BITS = NUM_NOTES + 1;
`else
  localparam int FRAME_BITS = NUM_NOTES;
`endif
  localparam int IDX_W = $clog2(FRAME_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_BITS);
  localparam logic [TO_W-1:0]  TO_PRE   = TO_W'(TIMEOUT_BITS - 1);

  note_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic [NUM_NOTES-1:0]    active_q, active_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic                    link_q, link_d;
  logic                    sample_tick;
  logic                    timeout_hit;
  logic                    frame_ok;

  note_bit_timer #(
    .BIT_PERIOD   (BIT_PERIOD),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_bit_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .sync_i        (note_serial_sync),
    .sample_tick_o (sample_tick)
  );

  // The tick that brings the supervision counter to its limit
  assign timeout_hit = sample_tick & (cnt_q == TO_PRE);

`ifdef NOTE_FRAME_PARITY_EN
  assign frame_ok = ~(^shift_q);
`else
  assign frame_ok = 1'b1;
`endif

  assign active      = active_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign link_up     = link_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      link_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      link_q   <= link_d;
    end
  end

  // Next state: a timeout abandons any frame in progress; COMMIT always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sample_tick && !timeout_hit && note_serial_sync) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (sample_tick && !note_serial_sync && (idx_q == IDX_LAST)) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: bits enter at the top of the shift register so bit 0 lands at the LSB
  always_comb begin
    shift_d  = shift_q;
    idx_d    = idx_q;
    active_d = active_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    link_d   = link_q;
    cnt_d    = cnt_q;
    if (sample_tick && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + TO_ONE;
    end
    if (state_q == COMMIT) begin
      idx_d = '0;
      if (frame_ok) begin
        active_d = shift_q[NUM_NOTES-1:0];
        valid_d  = 1'b1;
        link_d   = 1'b1;
        cnt_d    = '0;
      end else begin
        error_d = 1'b1;
      end
    end else if (timeout_hit) begin
      idx_d    = '0;
      active_d = '0;
      link_d   = 1'b0;
      error_d  = 1'b1;
    end else if (sample_tick) begin
      if (state_q == IDLE) begin
        if (note_serial_sync) begin
          shift_d = {note_serial_data, shift_q[FRAME_BITS-1:1]};
          idx_d   = IDX_ONE;
        end
      end else if (state_q == RECV) begin
        shift_d = {note_serial_data, shift_q[FRAME_BITS-1:1]};
        if (note_serial_sync) begin
          error_d = 1'b1;
          idx_d   = IDX_ONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end
  end

endmodule
